// File: rtl/sw_debounce.sv
`default_nettype none
//============================================================================
// Module   : sw_debounce
// Purpose  : Synchronises and debounces WIDTH slide switches against a shared
//            slow sample tick; emits a clean switch word and a change strobe.
//            Optional per-bit rise/fall pulses when SW_EDGE_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic             changed_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int C_CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int C_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    generate
        if (TICK_DIV < 1 || STABLE_TICKS < 1 || SYNC_STAGES < 2) begin : g_param_check
            $error("sw_debounce: illegal parameters (TICK_DIV>=1, STABLE_TICKS>=1, SYNC_STAGES>=2)");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
    logic [C_PRE_W-1:0]                  pre_q, pre_d;
    logic [WIDTH-1:0][C_CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                    sw_q, sw_d;
    logic                                changed_q, changed_d;
    logic [WIDTH-1:0]                    sw_sync;
    logic                                tick;

    assign sw_sync = sync_q[SYNC_STAGES-1];
    assign tick    = (pre_q == C_PRE_W'(TICK_DIV - 1));

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sw_raw_i};
        pre_d     = tick ? '0 : pre_q + C_PRE_W'(1);
        cnt_d     = cnt_q;
        sw_d      = sw_q;
        // Agreement restarts the count, so only an uninterrupted run of
        // disagreeing ticks can ever flip an output bit.
        for (int b = 0; b < WIDTH; b++) begin
            if (sw_sync[b] == sw_q[b]) begin
                cnt_d[b] = '0;
            end else if (tick) begin
                if (cnt_q[b] == C_CNT_W'(STABLE_TICKS - 1)) begin
                    sw_d[b]  = sw_sync[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + C_CNT_W'(1);
                end
            end
        end
        changed_d = |(sw_d ^ sw_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q    <= '0;
            pre_q     <= '0;
            cnt_q     <= '0;
            sw_q      <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            sw_q      <= sw_d;
            changed_q <= changed_d;
        end
    end

    assign sw_o      = sw_q;
    assign changed_o = changed_q;

`ifdef SW_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_comb begin
        rise_d = sw_d & ~sw_q;
        fall_d = sw_q & ~sw_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule
`default_nettype wire
